// File: rtl/slv_guard_iso_pkg.sv
// Shared types for the slave-guard isolator: FSM encodings, AXI response codes
// and the default AXI4 request/response structs used on both sides.
package slv_guard_iso_pkg;

  typedef enum logic [1:0] {
    PASS     = 2'd0,
    DRAIN    = 2'd1,
    ISOLATED = 2'd2
  } iso_state_e;

  typedef enum logic [1:0] {
    EW_IDLE = 2'd0,
    EW_DATA = 2'd1,
    EW_RESP = 2'd2
  } err_wr_state_e;

  typedef enum logic {
    ER_IDLE = 1'b0,
    ER_DATA = 1'b1
  } err_rd_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int unsigned AxiIdWidth   = 2;
  localparam int unsigned AxiAddrWidth = 32;
  localparam int unsigned AxiDataWidth = 32;

  typedef struct packed {
    logic [AxiIdWidth-1:0]   id;
    logic [AxiAddrWidth-1:0] addr;
    logic [7:0]              len;
  } axi_ax_chan_t;

  typedef struct packed {
    logic [AxiDataWidth-1:0]   data;
    logic [AxiDataWidth/8-1:0] strb;
    logic                      last;
  } axi_w_chan_t;

  typedef struct packed {
    logic [AxiIdWidth-1:0] id;
    logic [1:0]            resp;
  } axi_b_chan_t;

  typedef struct packed {
    logic [AxiIdWidth-1:0]   id;
    logic [AxiDataWidth-1:0] data;
    logic [1:0]              resp;
    logic                    last;
  } axi_r_chan_t;

  typedef struct packed {
    axi_ax_chan_t aw;
    logic         aw_valid;
    axi_w_chan_t  w;
    logic         w_valid;
    logic         b_ready;
    axi_ax_chan_t ar;
    logic         ar_valid;
    logic         r_ready;
  } axi_req_t;

  typedef struct packed {
    logic        aw_ready;
    logic        w_ready;
    axi_b_chan_t b;
    logic        b_valid;
    logic        ar_ready;
    axi_r_chan_t r;
    logic        r_valid;
  } axi_rsp_t;

endpackage

// File: rtl/slv_guard_err_slv.sv
// Error responder used while the subordinate is isolated: one write and one
// read in flight at a time, each answered with SLVERR.
module slv_guard_err_slv
  import slv_guard_iso_pkg::*;
#(
  parameter int unsigned IdWidth = 2
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               accept_i,
  input  logic               aw_valid_i,
  input  logic [IdWidth-1:0] aw_id_i,
  output logic               aw_ready_o,
  input  logic               w_valid_i,
  input  logic               w_last_i,
  output logic               w_ready_o,
  output logic               b_valid_o,
  output logic [IdWidth-1:0] b_id_o,
  input  logic               b_ready_i,
  input  logic               ar_valid_i,
  input  logic [IdWidth-1:0] ar_id_i,
  input  logic [7:0]         ar_len_i,
  output logic               ar_ready_o,
  output logic               r_valid_o,
  output logic [IdWidth-1:0] r_id_o,
  output logic               r_last_o,
  input  logic               r_ready_i,
  output logic               busy_o
);

  err_wr_state_e      wr_state_q;
  err_rd_state_e      rd_state_q;
  logic [IdWidth-1:0] wr_id_q;
  logic [IdWidth-1:0] rd_id_q;
  logic [7:0]         rd_len_q;
  logic [7:0]         rd_beat_q;

  // Write engine (AW -> W until last -> B) and read engine (AR -> len+1 R beats).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_state_q <= EW_IDLE;
      rd_state_q <= ER_IDLE;
      wr_id_q    <= '0;
      rd_id_q    <= '0;
      rd_len_q   <= '0;
      rd_beat_q  <= '0;
    end else begin
      unique case (wr_state_q)
        EW_IDLE: if (accept_i && aw_valid_i) begin
          wr_id_q    <= aw_id_i;
          wr_state_q <= EW_DATA;
        end
        EW_DATA: if (w_valid_i && w_last_i) wr_state_q <= EW_RESP;
        EW_RESP: if (b_ready_i) wr_state_q <= EW_IDLE;
        default: wr_state_q <= EW_IDLE;
      endcase
      unique case (rd_state_q)
        ER_IDLE: if (accept_i && ar_valid_i) begin
          rd_id_q    <= ar_id_i;
          rd_len_q   <= ar_len_i;
          rd_beat_q  <= '0;
          rd_state_q <= ER_DATA;
        end
        ER_DATA: if (r_ready_i) begin
          if (rd_beat_q == rd_len_q) rd_state_q <= ER_IDLE;
          else                       rd_beat_q  <= rd_beat_q + 8'd1;
        end
        default: rd_state_q <= ER_IDLE;
      endcase
    end
  end

  assign aw_ready_o = accept_i && (wr_state_q == EW_IDLE);
  assign w_ready_o  = (wr_state_q == EW_DATA);
  assign b_valid_o  = (wr_state_q == EW_RESP);
  assign b_id_o     = wr_id_q;
  assign ar_ready_o = accept_i && (rd_state_q == ER_IDLE);
  assign r_valid_o  = (rd_state_q == ER_DATA);
  assign r_id_o     = rd_id_q;
  assign r_last_o   = (rd_beat_q == rd_len_q);
  assign busy_o     = (wr_state_q != EW_IDLE) || (rd_state_q != ER_IDLE);

endmodule

// File: rtl/slv_guard_isolator.sv
// Isolator between the slave guard and its subordinate: forwards AXI4 traffic
// with outstanding limits, drains on isolate request, then answers SLVERR.
module slv_guard_isolator
  import slv_guard_iso_pkg::*;
#(
  parameter int unsigned IdWidth        = 2,
  parameter int unsigned MaxOutstanding = 8,
  parameter int unsigned DrainCycles    = 1024,
  parameter type         req_t          = axi_req_t,
  parameter type         rsp_t          = axi_rsp_t
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       isolate_i,
  input  req_t       slv_req_i,
  output rsp_t       slv_rsp_o,
  output req_t       mst_req_o,
  input  rsp_t       mst_rsp_i,
  output logic       isolated_o,
  output logic       drain_timeout_o,
  output logic [1:0] state_o
);

  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
  localparam int unsigned DcW  = (DrainCycles > 1) ? $clog2(DrainCycles) : 1;

  iso_state_e      state_q;
  logic [CntW-1:0] wr_cnt_q, wr_cnt_d;
  logic [CntW-1:0] rd_cnt_q, rd_cnt_d;
  logic [CntW-1:0] w_pend_q, w_pend_d;
  logic [DcW-1:0]  drain_cnt_q;
  logic            drain_timeout_q;

  logic aw_open, ar_open, w_open;
  logic aw_hs, ar_hs, w_last_hs, b_hs, r_last_hs;
  logic in_iso;

  logic               e_accept, e_aw_ready, e_w_ready, e_b_valid, e_ar_ready;
  logic               e_r_valid, e_r_last, e_busy;
  logic [IdWidth-1:0] e_b_id, e_r_id;

  assign in_iso   = (state_q == ISOLATED);
  assign e_accept = in_iso && isolate_i;

  slv_guard_err_slv #(
    .IdWidth (IdWidth)
  ) u_err_slv (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .accept_i   (e_accept),
    .aw_valid_i (slv_req_i.aw_valid),
    .aw_id_i    (slv_req_i.aw.id),
    .aw_ready_o (e_aw_ready),
    .w_valid_i  (slv_req_i.w_valid),
    .w_last_i   (slv_req_i.w.last),
    .w_ready_o  (e_w_ready),
    .b_valid_o  (e_b_valid),
    .b_id_o     (e_b_id),
    .b_ready_i  (slv_req_i.b_ready),
    .ar_valid_i (slv_req_i.ar_valid),
    .ar_id_i    (slv_req_i.ar.id),
    .ar_len_i   (slv_req_i.ar.len),
    .ar_ready_o (e_ar_ready),
    .r_valid_o  (e_r_valid),
    .r_id_o     (e_r_id),
    .r_last_o   (e_r_last),
    .r_ready_i  (slv_req_i.r_ready),
    .busy_o     (e_busy)
  );

  // Channel gating, handshake detection and next counter values.
  always_comb begin
    mst_req_o = slv_req_i;
    slv_rsp_o = mst_rsp_i;

    aw_open = (state_q == PASS) && (wr_cnt_q != CntW'(MaxOutstanding));
    ar_open = (state_q == PASS) && (rd_cnt_q != CntW'(MaxOutstanding));

    mst_req_o.aw_valid = slv_req_i.aw_valid & aw_open;
    slv_rsp_o.aw_ready = mst_rsp_i.aw_ready & aw_open;
    aw_hs              = slv_req_i.aw_valid & mst_rsp_i.aw_ready & aw_open;

    mst_req_o.ar_valid = slv_req_i.ar_valid & ar_open;
    slv_rsp_o.ar_ready = mst_rsp_i.ar_ready & ar_open;
    ar_hs              = slv_req_i.ar_valid & mst_rsp_i.ar_ready & ar_open;

    // aw_hs is never set in DRAIN, so this also covers the w_pend-only rule there.
    w_open             = !in_iso && ((w_pend_q != '0) || aw_hs);
    mst_req_o.w_valid  = slv_req_i.w_valid & w_open;
    slv_rsp_o.w_ready  = mst_rsp_i.w_ready & w_open;
    w_last_hs          = slv_req_i.w_valid & mst_rsp_i.w_ready & w_open & slv_req_i.w.last;

    b_hs      = !in_iso & mst_rsp_i.b_valid & slv_req_i.b_ready;
    r_last_hs = !in_iso & mst_rsp_i.r_valid & slv_req_i.r_ready & mst_rsp_i.r.last;

    if (in_iso) begin
      mst_req_o.b_ready  = 1'b1;
      mst_req_o.r_ready  = 1'b1;
      slv_rsp_o          = '0;
      slv_rsp_o.aw_ready = e_aw_ready;
      slv_rsp_o.w_ready  = e_w_ready;
      slv_rsp_o.b_valid  = e_b_valid;
      slv_rsp_o.b.id     = e_b_id;
      slv_rsp_o.b.resp   = RESP_SLVERR;
      slv_rsp_o.ar_ready = e_ar_ready;
      slv_rsp_o.r_valid  = e_r_valid;
      slv_rsp_o.r.id     = e_r_id;
      slv_rsp_o.r.resp   = RESP_SLVERR;
      slv_rsp_o.r.last   = e_r_last;
    end

    // Outputs are forced idle while reset is held so the pass-through paths
    // cannot leak valid/ready before the first clock edge.
    if (!rst_ni) begin
      mst_req_o = '0;
      slv_rsp_o = '0;
    end

    wr_cnt_d = wr_cnt_q + CntW'(aw_hs) - CntW'(b_hs);
    rd_cnt_d = rd_cnt_q + CntW'(ar_hs) - CntW'(r_last_hs);
    w_pend_d = w_pend_q + CntW'(aw_hs) - CntW'(w_last_hs);
  end

  // Mode FSM with outstanding counters, drain timer and timeout pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q         <= PASS;
      wr_cnt_q        <= '0;
      rd_cnt_q        <= '0;
      w_pend_q        <= '0;
      drain_cnt_q     <= '0;
      drain_timeout_q <= 1'b0;
    end else begin
      drain_timeout_q <= 1'b0;
      wr_cnt_q        <= wr_cnt_d;
      rd_cnt_q        <= rd_cnt_d;
      w_pend_q        <= w_pend_d;
      unique case (state_q)
        PASS: begin
          drain_cnt_q <= '0;
          if (isolate_i) state_q <= DRAIN;
        end
        DRAIN: begin
          drain_cnt_q <= drain_cnt_q + DcW'(1);
          if ((wr_cnt_q == '0) && (rd_cnt_q == '0) && (w_pend_q == '0)) begin
            state_q <= ISOLATED;
          end else if (drain_cnt_q == DcW'(DrainCycles - 1)) begin
            state_q         <= ISOLATED;
            drain_timeout_q <= 1'b1;
            wr_cnt_q        <= '0;
            rd_cnt_q        <= '0;
            w_pend_q        <= '0;
          end
        end
        ISOLATED: if (!isolate_i && !e_busy) state_q <= PASS;
        default: state_q <= PASS;
      endcase
    end
  end

  assign isolated_o      = in_iso;
  assign drain_timeout_o = drain_timeout_q;
  assign state_o         = state_q;

endmodule

// File: tb/tb_slv_guard_isolator.sv
// Directed self-checking bench for slv_guard_isolator.
module tb_slv_guard_isolator;
  import slv_guard_iso_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       isolate;
  axi_req_t   slv_req, mst_req;
  axi_rsp_t   slv_rsp, mst_rsp;
  logic       isolated, drain_to;
  logic [1:0] state;

  int nchk  = 0;
  int npass = 0;

  always #5 clk = ~clk;

  slv_guard_isolator #(
    .IdWidth        (2),
    .MaxOutstanding (8),
    .DrainCycles    (16)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .isolate_i       (isolate),
    .slv_req_i       (slv_req),
    .slv_rsp_o       (slv_rsp),
    .mst_req_o       (mst_req),
    .mst_rsp_i       (mst_rsp),
    .isolated_o      (isolated),
    .drain_timeout_o (drain_to),
    .state_o         (state)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    slv_req = '0;
    mst_rsp = '0;
  endtask

  task automatic apply_reset();
    clr();
    isolate = 1'b0;
    rst_n   = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    isolate = 1'b0;
    clr();
    slv_req.aw_valid = 1'b1;
    slv_req.b_ready  = 1'b1;
    mst_rsp.aw_ready = 1'b1;
    mst_rsp.b_valid  = 1'b1;
    #2;
    nchk++; if (state !== 2'd0) $display("FAIL rst_state: got %0d want 0", state); else npass++;
    nchk++; if (isolated !== 1'b0 || drain_to !== 1'b0) $display("FAIL rst_flags: got iso=%b to=%b want 0 0", isolated, drain_to); else npass++;
    nchk++; if (mst_req.aw_valid !== 1'b0 || slv_rsp.aw_ready !== 1'b0 || slv_rsp.b_valid !== 1'b0 || mst_req.b_ready !== 1'b0)
      $display("FAIL rst_vr: got awv=%b awr=%b bv=%b br=%b want 0", mst_req.aw_valid, slv_rsp.aw_ready, slv_rsp.b_valid, mst_req.b_ready); else npass++;
    nchk++; if (dut.wr_cnt_q !== 4'd0 || dut.rd_cnt_q !== 4'd0 || dut.w_pend_q !== 4'd0) $display("FAIL rst_cnt: got %0d %0d %0d want 0", dut.wr_cnt_q, dut.rd_cnt_q, dut.w_pend_q); else npass++;
    clr();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_pass();
    int bad;
    apply_reset();
    mst_rsp.aw_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      slv_req.aw_valid = 1'b1; slv_req.aw.id = 2'(i); slv_req.aw.len = 8'd3;
      #1;
      nchk++; if (mst_req.aw_valid !== 1'b1 || mst_req.aw.id !== 2'(i) || slv_rsp.aw_ready !== 1'b1)
        $display("FAIL pass_aw%0d: got v=%b id=%0d r=%b want 1 %0d 1", i, mst_req.aw_valid, mst_req.aw.id, slv_rsp.aw_ready, i); else npass++;
      step();
    end
    slv_req.aw_valid = 1'b0;
    #1;
    nchk++; if (dut.wr_cnt_q !== 4'd3 || dut.w_pend_q !== 4'd3) $display("FAIL pass_cnt3: got wr=%0d wp=%0d want 3 3", dut.wr_cnt_q, dut.w_pend_q); else npass++;
    bad = 0;
    mst_rsp.w_ready = 1'b1;
    slv_req.w_valid = 1'b1;
    for (int b = 0; b < 12; b++) begin
      slv_req.w.data = 32'(b); slv_req.w.last = ((b % 4) == 3);
      #1;
      if (mst_req.w_valid !== 1'b1 || mst_req.w.data !== 32'(b) || slv_rsp.w_ready !== 1'b1) bad++;
      step();
    end
    slv_req.w_valid = 1'b0;
    nchk++; if (bad !== 0) $display("FAIL pass_w: got %0d bad beats want 0", bad); else npass++;
    nchk++; if (dut.w_pend_q !== 4'd0) $display("FAIL pass_wpend: got %0d want 0", dut.w_pend_q); else npass++;
    slv_req.w_valid = 1'b1;
    #1;
    nchk++; if (mst_req.w_valid !== 1'b0 || slv_rsp.w_ready !== 1'b0) $display("FAIL w_orphan: got v=%b r=%b want 0 0", mst_req.w_valid, slv_rsp.w_ready); else npass++;
    slv_req.w_valid = 1'b0;
    slv_req.b_ready = 1'b1;
    mst_rsp.b_valid = 1'b1; mst_rsp.b.resp = RESP_OKAY;
    for (int i = 0; i < 3; i++) begin
      mst_rsp.b.id = 2'(i);
      #1;
      nchk++; if (slv_rsp.b_valid !== 1'b1 || slv_rsp.b.id !== 2'(i) || slv_rsp.b.resp !== 2'b00)
        $display("FAIL pass_b%0d: got v=%b id=%0d resp=%0d want 1 %0d 0", i, slv_rsp.b_valid, slv_rsp.b.id, slv_rsp.b.resp, i); else npass++;
      step();
    end
    mst_rsp.b_valid = 1'b0;
    #1;
    nchk++; if (dut.wr_cnt_q !== 4'd0) $display("FAIL pass_wr0: got %0d want 0", dut.wr_cnt_q); else npass++;
    mst_rsp.ar_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      slv_req.ar_valid = 1'b1; slv_req.ar.id = 2'(i + 1); slv_req.ar.len = 8'd0;
      step();
    end
    slv_req.ar_valid = 1'b0;
    #1;
    nchk++; if (dut.rd_cnt_q !== 4'd2) $display("FAIL pass_rd2: got %0d want 2", dut.rd_cnt_q); else npass++;
    slv_req.r_ready = 1'b1;
    mst_rsp.r_valid = 1'b1; mst_rsp.r.last = 1'b1; mst_rsp.r.resp = RESP_OKAY;
    for (int i = 0; i < 2; i++) begin
      mst_rsp.r.id = 2'(i + 1); mst_rsp.r.data = 32'hA0 + 32'(i);
      #1;
      nchk++; if (slv_rsp.r_valid !== 1'b1 || slv_rsp.r.data !== 32'hA0 + 32'(i) || slv_rsp.r.resp !== 2'b00 || slv_rsp.r.id !== 2'(i + 1))
        $display("FAIL pass_r%0d: got v=%b d=%0h resp=%0d want 1 %0h 0", i, slv_rsp.r_valid, slv_rsp.r.data, slv_rsp.r.resp, 32'hA0 + i); else npass++;
      step();
    end
    mst_rsp.r_valid = 1'b0;
    #1;
    nchk++; if (dut.rd_cnt_q !== 4'd0) $display("FAIL pass_rd0: got %0d want 0", dut.rd_cnt_q); else npass++;
  endtask

  task automatic test_cap();
    apply_reset();
    slv_req.aw_valid = 1'b1;
    mst_rsp.aw_ready = 1'b1;
    repeat (8) step();
    nchk++; if (dut.wr_cnt_q !== 4'd8) $display("FAIL cap_cnt: got %0d want 8", dut.wr_cnt_q); else npass++;
    nchk++; if (slv_rsp.aw_ready !== 1'b0 || mst_req.aw_valid !== 1'b0) $display("FAIL cap_gate: got r=%b v=%b want 0 0", slv_rsp.aw_ready, mst_req.aw_valid); else npass++;
    step();
    mst_rsp.b_valid = 1'b1;
    slv_req.b_ready = 1'b1;
    #1;
    nchk++; if (slv_rsp.aw_ready !== 1'b0 || dut.wr_cnt_q !== 4'd8) $display("FAIL cap_hold: got r=%b cnt=%0d want 0 8", slv_rsp.aw_ready, dut.wr_cnt_q); else npass++;
    step();
    mst_rsp.b_valid = 1'b0;
    #1;
    nchk++; if (slv_rsp.aw_ready !== 1'b1 || dut.wr_cnt_q !== 4'd7) $display("FAIL cap_open: got r=%b cnt=%0d want 1 7", slv_rsp.aw_ready, dut.wr_cnt_q); else npass++;
    step();
    slv_req.aw_valid = 1'b0;
    #1;
    nchk++; if (dut.wr_cnt_q !== 4'd8) $display("FAIL cap_9th: got %0d want 8", dut.wr_cnt_q); else npass++;
  endtask

  task automatic test_drain();
    int bad;
    int to_seen;
    apply_reset();
    mst_rsp.aw_ready = 1'b1;
    slv_req.aw_valid = 1'b1; slv_req.aw.id = 2'd0; slv_req.aw.len = 8'd1;
    step();
    slv_req.aw.id = 2'd1; slv_req.aw.len = 8'd3;
    step();
    slv_req.aw_valid = 1'b0;
    mst_rsp.w_ready  = 1'b1;
    slv_req.w_valid  = 1'b1;
    for (int b = 0; b < 4; b++) begin
      slv_req.w.last = (b == 1);
      step();
    end
    slv_req.w_valid = 1'b0;
    #1;
    nchk++; if (dut.wr_cnt_q !== 4'd2 || dut.w_pend_q !== 4'd1) $display("FAIL dr_pre: got wr=%0d wp=%0d want 2 1", dut.wr_cnt_q, dut.w_pend_q); else npass++;
    isolate = 1'b1;
    step();
    nchk++; if (state !== 2'd1) $display("FAIL dr_state: got %0d want 1", state); else npass++;
    slv_req.aw_valid = 1'b1; slv_req.aw.id = 2'd3;
    #1;
    nchk++; if (slv_rsp.aw_ready !== 1'b0 || mst_req.aw_valid !== 1'b0) $display("FAIL dr_aw: got r=%b v=%b want 0 0", slv_rsp.aw_ready, mst_req.aw_valid); else npass++;
    slv_req.aw_valid = 1'b0;
    bad = 0;
    slv_req.w_valid = 1'b1;
    for (int b = 0; b < 2; b++) begin
      slv_req.w.last = (b == 1);
      #1;
      if (mst_req.w_valid !== 1'b1 || slv_rsp.w_ready !== 1'b1) bad++;
      step();
    end
    nchk++; if (bad !== 0) $display("FAIL dr_w: got %0d bad beats want 0", bad); else npass++;
    slv_req.w.last = 1'b0;
    #1;
    nchk++; if (mst_req.w_valid !== 1'b0 || dut.w_pend_q !== 4'd0) $display("FAIL dr_wstop: got v=%b wp=%0d want 0 0", mst_req.w_valid, dut.w_pend_q); else npass++;
    slv_req.w_valid = 1'b0;
    bad = 0;
    slv_req.b_ready = 1'b1;
    mst_rsp.b_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      mst_rsp.b.id = 2'(i);
      #1;
      if (slv_rsp.b_valid !== 1'b1 || slv_rsp.b.id !== 2'(i)) bad++;
      step();
    end
    mst_rsp.b_valid = 1'b0;
    nchk++; if (bad !== 0) $display("FAIL dr_b: got %0d bad B want 0", bad); else npass++;
    to_seen = 0;
    for (int k = 0; k < 4 && state !== 2'd2; k++) begin
      if (drain_to === 1'b1) to_seen++;
      step();
    end
    if (drain_to === 1'b1) to_seen++;
    nchk++; if (state !== 2'd2 || isolated !== 1'b1) $display("FAIL dr_iso: got st=%0d iso=%b want 2 1", state, isolated); else npass++;
    nchk++; if (to_seen !== 0) $display("FAIL dr_noto: got %0d pulses want 0", to_seen); else npass++;
  endtask

  task automatic test_timeout();
    int bad;
    apply_reset();
    mst_rsp.ar_ready = 1'b1;
    slv_req.ar_valid = 1'b1;
    step();
    clr();
    isolate = 1'b1;
    step();
    bad = 0;
    for (int k = 1; k < 16; k++) begin
      step();
      if (state !== 2'd1 || drain_to !== 1'b0) bad++;
    end
    nchk++; if (bad !== 0) $display("FAIL to_early: got %0d bad cycles want 0", bad); else npass++;
    step();
    nchk++; if (drain_to !== 1'b1 || state !== 2'd2) $display("FAIL to_pulse: got to=%b st=%0d want 1 2", drain_to, state); else npass++;
    nchk++; if (dut.rd_cnt_q !== 4'd0) $display("FAIL to_clear: got %0d want 0", dut.rd_cnt_q); else npass++;
    step();
    nchk++; if (drain_to !== 1'b0) $display("FAIL to_once: got %b want 0", drain_to); else npass++;
  endtask

  task automatic test_isolated();
    int sub_v;
    int bad;
    sub_v = 0;
    slv_req.aw_valid = 1'b1; slv_req.aw.id = 2'd2; slv_req.aw.len = 8'd1;
    mst_rsp.aw_ready = 1'b1;
    #1;
    nchk++; if (slv_rsp.aw_ready !== 1'b1 || mst_req.aw_valid !== 1'b0) $display("FAIL iso_aw: got r=%b v=%b want 1 0", slv_rsp.aw_ready, mst_req.aw_valid); else npass++;
    nchk++; if (mst_req.b_ready !== 1'b1 || mst_req.r_ready !== 1'b1) $display("FAIL iso_sink: got b=%b r=%b want 1 1", mst_req.b_ready, mst_req.r_ready); else npass++;
    step();
    slv_req.aw_valid = 1'b0;
    slv_req.ar_valid = 1'b0;
    #1;
    nchk++; if (slv_rsp.aw_ready !== 1'b0) $display("FAIL iso_awbusy: got %b want 0", slv_rsp.aw_ready); else npass++;
    bad = 0;
    slv_req.w_valid = 1'b1;
    for (int b = 0; b < 2; b++) begin
      slv_req.w.last = (b == 1);
      #1;
      if (slv_rsp.w_ready !== 1'b1) bad++;
      if (mst_req.w_valid !== 1'b0) sub_v++;
      step();
    end
    slv_req.w_valid = 1'b0;
    nchk++; if (bad !== 0) $display("FAIL iso_w: got %0d bad beats want 0", bad); else npass++;
    nchk++; if (slv_rsp.b_valid !== 1'b1 || slv_rsp.b.id !== 2'd2 || slv_rsp.b.resp !== 2'b10)
      $display("FAIL iso_b: got v=%b id=%0d resp=%0d want 1 2 2", slv_rsp.b_valid, slv_rsp.b.id, slv_rsp.b.resp); else npass++;
    step();
    nchk++; if (slv_rsp.b_valid !== 1'b1) $display("FAIL iso_bhold: got %b want 1", slv_rsp.b_valid); else npass++;
    slv_req.b_ready = 1'b1;
    step();
    slv_req.b_ready = 1'b0;
    nchk++; if (slv_rsp.b_valid !== 1'b0) $display("FAIL iso_bdone: got %b want 0", slv_rsp.b_valid); else npass++;
    slv_req.ar_valid = 1'b1; slv_req.ar.id = 2'd1; slv_req.ar.len = 8'd3;
    mst_rsp.ar_ready = 1'b1;
    #1;
    nchk++; if (slv_rsp.ar_ready !== 1'b1) $display("FAIL iso_ar: got %b want 1", slv_rsp.ar_ready); else npass++;
    if (mst_req.ar_valid !== 1'b0) sub_v++;
    step();
    slv_req.ar_valid = 1'b0;
    slv_req.r_ready  = 1'b1;
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      #1;
      if (slv_rsp.r_valid !== 1'b1 || slv_rsp.r.resp !== 2'b10 || slv_rsp.r.id !== 2'd1 ||
          slv_rsp.r.data !== 32'd0 || slv_rsp.r.last !== (k == 3)) bad++;
      if (mst_req.aw_valid !== 1'b0 || mst_req.w_valid !== 1'b0 || mst_req.ar_valid !== 1'b0) sub_v++;
      step();
    end
    nchk++; if (bad !== 0) $display("FAIL iso_r: got %0d bad beats want 0", bad); else npass++;
    nchk++; if (slv_rsp.r_valid !== 1'b0) $display("FAIL iso_rdone: got %b want 0", slv_rsp.r_valid); else npass++;
    nchk++; if (sub_v !== 0) $display("FAIL iso_subv: got %0d valids want 0", sub_v); else npass++;
    slv_req.r_ready = 1'b0;
    mst_rsp = '0;
  endtask

  task automatic test_recover();
    int bad;
    slv_req.ar_valid = 1'b1; slv_req.ar.id = 2'd3; slv_req.ar.len = 8'd2;
    step();
    slv_req.ar_valid = 1'b0;
    isolate = 1'b0;
    step();
    nchk++; if (state !== 2'd2) $display("FAIL rec_hold: got %0d want 2", state); else npass++;
    slv_req.r_ready = 1'b1;
    bad = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      if (slv_rsp.r_valid !== 1'b1 || slv_rsp.r.last !== (k == 2)) bad++;
      step();
    end
    nchk++; if (bad !== 0 || state !== 2'd2) $display("FAIL rec_beats: got bad=%0d st=%0d want 0 2", bad, state); else npass++;
    step();
    nchk++; if (state !== 2'd0 || isolated !== 1'b0) $display("FAIL rec_pass: got st=%0d iso=%b want 0 0", state, isolated); else npass++;
    clr();
  endtask

  task automatic test_reset_drain();
    apply_reset();
    mst_rsp.ar_ready = 1'b1;
    slv_req.ar_valid = 1'b1;
    step();
    clr();
    isolate = 1'b1;
    step();
    slv_req.r_ready = 1'b1;
    mst_rsp.r_valid = 1'b1;
    mst_rsp.r.last  = 1'b0;
    #1;
    nchk++; if (state !== 2'd1 || slv_rsp.r_valid !== 1'b1) $display("FAIL rd_pre: got st=%0d rv=%b want 1 1", state, slv_rsp.r_valid); else npass++;
    rst_n = 1'b0;
    #1;
    nchk++; if (state !== 2'd0 || isolated !== 1'b0 || drain_to !== 1'b0) $display("FAIL rd_async: got st=%0d iso=%b to=%b want 0 0 0", state, isolated, drain_to); else npass++;
    nchk++; if (slv_rsp.r_valid !== 1'b0 || mst_req.r_ready !== 1'b0 || dut.rd_cnt_q !== 4'd0)
      $display("FAIL rd_outs: got rv=%b rr=%b cnt=%0d want 0 0 0", slv_rsp.r_valid, mst_req.r_ready, dut.rd_cnt_q); else npass++;
    clr();
    isolate = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_pass();
    test_cap();
    test_drain();
    test_timeout();
    test_isolated();
    test_recover();
    test_reset_drain();
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
